// File: rtl/phase_prog_pkg.sv
// Shared definitions for the phase-delay program link (transmit and receive sides).
package phase_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int   FRAME_OVERHEAD = 4;
    localparam logic START_BIT      = 1'b0;
    localparam logic MARKER_BIT     = 1'b1;
    localparam logic STOP_BIT       = 1'b1;

    function automatic int frame_len(input int n);
        return n + FRAME_OVERHEAD;
    endfunction

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phase_prog_serial_tx_if.sv
// Program-number handshake and serial-line bundle between controller logic and the transmitter.
interface phase_prog_serial_tx_if #(
    parameter int PROG_NUM_SIZE = 7
);
    // A number transfers on a rising edge where prog_valid && prog_ready; prog_valid while
    // prog_ready is low is ignored (no queue), so the master holds or retries.
    logic [PROG_NUM_SIZE-1:0] prog_in;
    logic                     prog_valid;
    logic                     prog_ready;
    logic                     ser_out;
    logic                     busy;
    logic                     frame_done;

    modport master (
        output prog_in,
        output prog_valid,
        input  prog_ready,
        input  ser_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  prog_in,
        input  prog_valid,
        output prog_ready,
        output ser_out,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/phase_prog_serial_tx_bit_timer.sv
// Bit-period divider: strobes o_bit_tick on the last clk of every CLKS_PER_BIT-clk bit.
module phase_prog_bit_timer
    import phase_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_bit_tick
);

    localparam int            CW       = cnt_width(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_clk_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_clk_cnt <= '0;
        end else if (i_en) begin
            r_clk_cnt <= (r_clk_cnt == LAST_CLK) ? '0 : r_clk_cnt + CW'(1);
        end
    end

    assign o_bit_tick = i_en && (r_clk_cnt == LAST_CLK);

endmodule

// File: rtl/phase_prog_serial_tx.sv
// Phase-delay program transmitter: frames a program number as start/marker/data/parity/stop.
// Optional auto-refresh of the last number in IDLE when PROG_TX_REPEAT_EN is defined.
module phase_prog_serial_tx
    import phase_prog_pkg::*;
#(
    parameter int PROG_NUM_SIZE = 7,
    parameter int CLKS_PER_BIT  = 4,
    parameter int GAP_BITS      = 2,
    parameter int REPEAT_BITS   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    phase_prog_serial_tx_if.slave        bus,
    output state_t                       o_dbg_state
);

    localparam int FRAME_BITS = frame_len(PROG_NUM_SIZE);
    localparam int BIT_MAX    = (FRAME_BITS - 1 > GAP_BITS - 1) ? FRAME_BITS - 1 : GAP_BITS - 1;
    localparam int BW         = cnt_width(BIT_MAX);
    localparam logic [BW-1:0] LAST_FRAME_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] LAST_GAP_BIT   = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [BW-1:0]            r_bit_cnt;
    logic [PROG_NUM_SIZE-1:0] r_shadow;
    logic                     r_parity;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_bit_tick;
    logic                     w_frame_done;
    logic                     w_rep_expire;
    logic [FRAME_BITS-1:0]    w_frame;
    logic [FRAME_BITS-1:0]    w_frame_sh;

    assign w_accept = bus.prog_valid && (r_state == IDLE);

    phase_prog_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == IDLE),
        .i_en       (r_state != IDLE),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                // A fresh number takes priority over an auto-refresh in the same cycle.
                if (w_accept) begin
                    w_next_state = SHIFT;
                    w_load       = 1'b1;
                end else if (w_rep_expire) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_bit_tick && (r_bit_cnt == LAST_FRAME_BIT)) begin
                    w_frame_done = 1'b1;
                    w_next_state = (GAP_BITS > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (w_bit_tick && (r_bit_cnt == LAST_GAP_BIT)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The bit counter restarts on every state change, so SHIFT and GAP both begin at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (r_state != w_next_state) begin
            r_bit_cnt <= '0;
        end else if (w_bit_tick) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_shadow <= bus.prog_in;
            r_parity <= ~^bus.prog_in;
        end
    end

`ifdef PROG_TX_REPEAT_EN
    localparam int            REP_CLKS = REPEAT_BITS * CLKS_PER_BIT;
    localparam int            RW       = cnt_width(REP_CLKS - 1);
    localparam logic [RW-1:0] LAST_REP = RW'(REP_CLKS - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (w_load) begin
                r_armed <= 1'b1;
            end
            if ((r_state != IDLE) || w_accept || !r_armed || w_rep_expire) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end

    assign w_rep_expire = (r_state == IDLE) && r_armed && (r_rep_cnt == LAST_REP);
`else
    // Refresh disabled: the expiry term is a constant zero and no counter exists.
    assign w_rep_expire = (REPEAT_BITS < 0);
`endif

    // Frame laid out start-bit-first at the MSB; shifting by the bit index exposes the current bit.
    assign w_frame    = {START_BIT, MARKER_BIT, r_shadow, r_parity, STOP_BIT};
    assign w_frame_sh = w_frame << r_bit_cnt;

    assign bus.ser_out    = (r_state == SHIFT) ? w_frame_sh[FRAME_BITS-1] : 1'b1;
    assign bus.busy       = (r_state != IDLE);
    assign bus.prog_ready = (r_state == IDLE);
    assign bus.frame_done = w_frame_done;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_phase_prog_serial_tx.sv
// Scoreboard bench for phase_prog_serial_tx: driver pushes expected frames, monitor decodes the line.
module tb_phase_prog_serial_tx;
    import phase_prog_pkg::*;

    localparam int N    = 7;
    localparam int CPB  = 4;
    localparam int GAPB = 2;
    localparam int REP  = 64;
    localparam int FB   = N + 4;
    localparam int FCLK = FB * CPB;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_prog_serial_tx_if #(.PROG_NUM_SIZE(N)) bus ();
    state_t dbg_state;

    phase_prog_serial_tx #(
        .PROG_NUM_SIZE (N),
        .CLKS_PER_BIT  (CPB),
        .GAP_BITS      (GAPB),
        .REPEAT_BITS   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // scoreboard state
    logic [FB-1:0] exp_q[$];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  n_frames  = 0;
    int  last_gap  = 0;
    int  stray_fd  = 0;
    bit  abort_ok  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: decodes one frame per falling start edge and compares with the queue head
    initial begin : monitor
        int            idle_cnt;
        logic [FB-1:0] got;
        logic          cur;
        bit            hold_ok, done_ok, busy_ok, aborted;
        idle_cnt = 0;
        cur      = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                idle_cnt = 0;
            end else if (bus.ser_out === 1'b0) begin
                last_gap = idle_cnt;
                idle_cnt = 0;
                got      = '0;
                hold_ok  = 1'b1;
                done_ok  = 1'b1;
                busy_ok  = 1'b1;
                aborted  = 1'b0;
                for (int i = 0; i < FCLK; i++) begin
                    if (i > 0) @(negedge clk);
                    if (bus.busy !== 1'b1) begin
                        if (abort_ok) begin
                            aborted = 1'b1;
                            break;
                        end
                        busy_ok = 1'b0;
                    end
                    if (i % CPB == 0) begin
                        cur = bus.ser_out;
                        got = {got[FB-2:0], cur};
                    end else if (bus.ser_out !== cur) begin
                        hold_ok = 1'b0;
                    end
                    if (bus.frame_done !== (i == FCLK - 1)) done_ok = 1'b0;
                end
                if (aborted) begin
                    abort_ok = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    idle_cnt = 1;
                end else begin
                    n_frames++;
                    check("frame_busy", busy_ok, 1);
                    check("frame_bit_hold", hold_ok, 1);
                    check("frame_done_timing", done_ok, 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %b expected no frame", got);
                    end else begin
                        check("frame_bits", got, exp_q.pop_front());
                    end
                end
            end else begin
                idle_cnt++;
                if (bus.frame_done !== 1'b0) stray_fd++;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [N-1:0] v);
        int t;
        t = 0;
        @(negedge clk);
        bus.prog_in    = v;
        bus.prog_valid = 1'b1;
        while (bus.prog_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no prog_ready expected prog_ready within 200 clks");
        end
        @(negedge clk);
        bus.prog_valid = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] v, input logic [FB-1:0] frame);
        exp_q.push_back(frame);
        send(v);
        check("accept_busy", bus.busy, 1);
        check("accept_ready_low", bus.prog_ready, 0);
        check("accept_start_bit", bus.ser_out, 0);
    endtask

    // counts clks from the first cycle after accept (n=1) to the first IDLE cycle
    task automatic wait_ready(output int n);
        n = 1;
        while (bus.prog_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected TB_RESULT before 400000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int exp_frames;
        bus.prog_in    = '0;
        bus.prog_valid = 1'b0;
        exp_frames     = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ser_out", bus.ser_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.prog_ready, 1);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_state", dbg_state, IDLE);

        // 32: start 0, marker 1, 0100000, parity 0, stop 1; ready on clk 53 after accept
        issue(7'd32, 11'b0_1_0100000_0_1);
        exp_frames++;
        wait_ready(n);
        check("ready_latency_32", n, 53);
        check("idle_state", dbg_state, IDLE);

        repeat (5) @(negedge clk);
        issue(7'd0, 11'b0_1_0000000_1_1);
        exp_frames++;
        wait_ready(n);
        check("ready_latency_0", n, 53);
        issue(7'd127, 11'b0_1_1111111_0_1);
        exp_frames++;
        wait_ready(n);
        issue(7'd63, 11'b0_1_0111111_1_1);
        exp_frames++;
        wait_ready(n);

        // valid with 96 at clk 10 of an active frame must be ignored
        repeat (4) @(negedge clk);
        issue(7'd10, 11'b0_1_0001010_1_1);
        exp_frames++;
        repeat (9) @(negedge clk);
        bus.prog_in    = 7'd96;
        bus.prog_valid = 1'b1;
        @(negedge clk);
        bus.prog_valid = 1'b0;
        wait_ready(n);
        repeat (60) @(negedge clk);
        check("ignored_no_queue", exp_q.size(), 0);

        // reset during data bit 3 (frame bit 5, clks 21..24)
        issue(7'd127, 11'b0_1_1111111_0_1);
        repeat (21) @(negedge clk);
        abort_ok = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ser_out", bus.ser_out, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready", bus.prog_ready, 1);
        repeat (3) @(negedge clk);
        issue(7'd5, 11'b0_1_0000101_1_1);
        exp_frames++;
        wait_ready(n);
        check("abort_consumed", abort_ok, 0);

        // back-to-back with valid held: 8 gap clks plus the single IDLE accept cycle
        exp_q.push_back(11'b0_1_0010000_0_1);
        exp_q.push_back(11'b0_1_1000000_0_1);
        send(7'd16);
        bus.prog_in    = 7'd64;
        bus.prog_valid = 1'b1;
        n = 0;
        while (bus.prog_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.prog_valid = 1'b0;
        check("b2b_accept_clk", n + 1, 53);
        check("b2b_start_bit", bus.ser_out, 0);
        wait_ready(n);
        check("b2b_gap_clks", last_gap, GAPB * CPB + 1);
        exp_frames += 2;

`ifdef PROG_TX_REPEAT_EN
        issue(7'd32, 11'b0_1_0100000_0_1);
        exp_frames++;
        wait_ready(n);
        exp_q.push_back(11'b0_1_0100000_0_1);
        exp_frames++;
        n = 0;
        while (bus.ser_out !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("repeat_delay", n, REP * CPB);
        check("repeat_ready_low", bus.prog_ready, 0);
        wait_ready(n);
        repeat (REP * CPB - 1) @(negedge clk);
        exp_q.push_back(11'b0_1_0000001_0_1);
        exp_frames++;
        bus.prog_in    = 7'd1;
        bus.prog_valid = 1'b1;
        @(negedge clk);
        bus.prog_valid = 1'b0;
        check("expiry_accept_start", bus.ser_out, 0);
        wait_ready(n);
`endif

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("frame_count", n_frames, exp_frames);
        check("stray_frame_done", stray_fd, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
